// File: rtl/sp_push_unit_if.sv
// Call-path push port bundle: control-unit request, SP register update
// and the byte-wide data-memory write handshake.
//   master : the push unit (drives sp_out/sp_we/busy/mem_*/overflow)
//   slave  : the surrounding control unit, SP register and memory
interface sp_push_unit_if;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    logic          call_enable;
    logic [AW-1:0] ret_addr;
    logic [AW-1:0] sp_in;
    logic [AW-1:0] sp_out;
    logic          sp_we;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_ack;
    logic          overflow;

    modport master (
        input  call_enable, ret_addr, sp_in, mem_ack,
        output sp_out, sp_we, busy, mem_addr, mem_wdata, mem_we, overflow
    );

    modport slave (
        output call_enable, ret_addr, sp_in, mem_ack,
        input  sp_out, sp_we, busy, mem_addr, mem_wdata, mem_we, overflow
    );
endinterface

// File: rtl/sp_push_unit.sv
// sp_push_unit: pushes a 16-bit return address on a CALL as two byte writes
// (high byte at SP-1, low byte at SP-2) and then loads SP-2 into the SP
// register with a one-cycle sp_we strobe.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : sp_push_unit_if.master (call_enable, ret_addr, sp_in,
//              sp_out, sp_we, busy, mem_addr, mem_wdata, mem_we, mem_ack,
//              overflow)
// Build option: define SP_PUSH_OVF_CHECK_EN to reject pushes whose captured
// SP is below STACK_LIMIT+2 (sticky overflow flag, ERR state).
module sp_push_unit #(
    parameter logic [15:0] STACK_LIMIT = 16'h0100
) (
    input  logic           clk,
    input  logic           rst,
    sp_push_unit_if.master bus
);
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

`ifdef SP_PUSH_OVF_CHECK_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_HI = 3'd1,
        WR_LO = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    // Computed one bit wider so a limit near the top of memory cannot wrap.
    localparam logic [AW:0] OVF_THRESH = (AW+1)'(STACK_LIMIT) + (AW+1)'(2);
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_HI = 3'd1,
        WR_LO = 3'd2,
        DONE  = 3'd3
    } state_t;

    // No limit check in this build; the parameter only keeps both builds
    // sharing one parameter list and folds to a constant zero.
    localparam logic OVF_TIE = 1'b0 & (|STACK_LIMIT);
`endif

    state_t        state_q, state_d;
    logic [AW-1:0] ra_q, ra_d;
    logic [AW-1:0] sp0_q, sp0_d;
    logic          ovf_set;

    logic [AW-1:0] sp_out_q, sp_out_d;
    logic          sp_we_q, sp_we_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;
    logic          ovf_q, ovf_d;

    // State, captured operands and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ra_q        <= '0;
            sp0_q       <= '0;
            sp_out_q    <= '0;
            sp_we_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ra_q        <= ra_d;
            sp0_q       <= sp0_d;
            sp_out_q    <= sp_out_d;
            sp_we_q     <= sp_we_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next state, then outputs decoded from the next state so they appear
    // registered in the same cycle the FSM enters that state.
    always_comb begin
        state_d     = state_q;
        ra_d        = ra_q;
        sp0_d       = sp0_q;
`ifdef SP_PUSH_OVF_CHECK_EN
        ovf_set     = 1'b0;
`else
        ovf_set     = OVF_TIE;
`endif
        sp_out_d    = sp_out_q;
        sp_we_d     = 1'b0;
        busy_d      = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.call_enable) begin
                    ra_d  = bus.ret_addr;
                    sp0_d = bus.sp_in;
`ifdef SP_PUSH_OVF_CHECK_EN
                    if ((AW+1)'(bus.sp_in) < OVF_THRESH) begin
                        ovf_set = 1'b1;
                        state_d = ERR;
                    end else begin
                        state_d = WR_HI;
                    end
`else
                    state_d = WR_HI;
`endif
                end
            end
            WR_HI: if (bus.mem_ack) state_d = WR_LO;
            WR_LO: if (bus.mem_ack) state_d = DONE;
            DONE:  state_d = IDLE;
`ifdef SP_PUSH_OVF_CHECK_EN
            ERR:   state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        case (state_d)
            WR_HI: begin
                busy_d      = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = sp0_d - AW'(1);
                mem_wdata_d = ra_d[AW-1 -: DW];
            end
            WR_LO: begin
                busy_d      = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = sp0_d - AW'(2);
                mem_wdata_d = ra_d[DW-1:0];
            end
            DONE: begin
                busy_d   = 1'b1;
                sp_we_d  = 1'b1;
                sp_out_d = sp0_d - AW'(2);
            end
`ifdef SP_PUSH_OVF_CHECK_EN
            ERR: busy_d = 1'b1;
`endif
            default: ;
        endcase

        ovf_d = ovf_q | ovf_set;
    end

    assign bus.sp_out    = sp_out_q;
    assign bus.sp_we     = sp_we_q;
    assign bus.busy      = busy_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_sp_push_unit.sv
// Testbench for sp_push_unit: directed pushes with hand-computed expected
// byte writes and SP updates queued in a scoreboard, checked by an
// independent monitor on the falling edge.
module tb_sp_push_unit;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sp_push_unit_if ifc ();

    sp_push_unit #(.STACK_LIMIT(16'h0100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [23:0] exp_wr[$];
    logic [15:0] exp_sp[$];

    int          ack_wait  = 0;
    bit          ack_block = 1'b0;
    int          wcnt      = 0;
    bit          prev_wait = 1'b0;
    logic [23:0] prev_wr   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: acknowledges each write after ack_wait idle cycles.
    initial begin
        ifc.mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!ifc.mem_we || ack_block) begin
                ifc.mem_ack = 1'b0;
                wcnt = 0;
            end else if (wcnt >= ack_wait) begin
                ifc.mem_ack = 1'b1;
                wcnt = 0;
            end else begin
                ifc.mem_ack = 1'b0;
                wcnt++;
            end
        end
    end

    // Monitor: completed writes and SP updates against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (ifc.mem_we) begin
                if (prev_wait)
                    check("wr_hold", 32'({ifc.mem_addr, ifc.mem_wdata}), 32'(prev_wr));
                if (ifc.mem_ack) begin
                    prev_wait = 1'b0;
                    if (exp_wr.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write: got %h expected none", {ifc.mem_addr, ifc.mem_wdata});
                    end else begin
                        check("mem_write", 32'({ifc.mem_addr, ifc.mem_wdata}), 32'(exp_wr.pop_front()));
                    end
                end else begin
                    prev_wait = 1'b1;
                    prev_wr   = {ifc.mem_addr, ifc.mem_wdata};
                end
            end else begin
                prev_wait = 1'b0;
            end
            if (ifc.sp_we) begin
                if (exp_sp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_sp_we: got %h expected none", ifc.sp_out);
                end else begin
                    check("sp_out", 32'(ifc.sp_out), 32'(exp_sp.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // One push; exp_lat is the cycle number in which sp_we must appear.
    task automatic push(input logic [15:0] sp, input logic [15:0] ra,
                        input logic [15:0] a_hi, input logic [7:0] d_hi,
                        input logic [15:0] a_lo, input logic [7:0] d_lo,
                        input logic [15:0] exp_spv, input int exp_lat, input bit repulse);
        int cyc;
        exp_wr.push_back({a_hi, d_hi});
        exp_wr.push_back({a_lo, d_lo});
        exp_sp.push_back(exp_spv);
        @(posedge clk);
        #1;
        ifc.call_enable = 1'b1;
        ifc.sp_in       = sp;
        ifc.ret_addr    = ra;
        @(posedge clk);
        #1;
        ifc.call_enable = 1'b0;
        @(negedge clk);
        cyc = 1;
        check("busy_c1", 32'(ifc.busy), 32'd1);
        check("mem_we_c1", 32'(ifc.mem_we), 32'd1);
        if (repulse) begin
            ifc.call_enable = 1'b1;
            ifc.ret_addr    = 16'h5555;
            ifc.sp_in       = 16'h4000;
        end
        while (!ifc.sp_we && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) ifc.call_enable = 1'b0;
        end
        check("sp_we_cycle", 32'(cyc), 32'(exp_lat));
        @(negedge clk);
        check("busy_idle", 32'(ifc.busy), 32'd0);
        check("sp_we_pulse", 32'(ifc.sp_we), 32'd0);
        check("sp_out_hold", 32'(ifc.sp_out), 32'(exp_spv));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sp_out"},    32'(ifc.sp_out),    32'd0);
        check({tag, "_sp_we"},     32'(ifc.sp_we),     32'd0);
        check({tag, "_busy"},      32'(ifc.busy),      32'd0);
        check({tag, "_mem_we"},    32'(ifc.mem_we),    32'd0);
        check({tag, "_mem_addr"},  32'(ifc.mem_addr),  32'd0);
        check({tag, "_mem_wdata"}, 32'(ifc.mem_wdata), 32'd0);
        check({tag, "_overflow"},  32'(ifc.overflow),  32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        ifc.call_enable = 1'b0;
        ifc.ret_addr    = '0;
        ifc.sp_in       = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic push, zero-wait memory.
        push(16'h8000, 16'h1234, 16'h7FFF, 8'h12, 16'h7FFE, 8'h34, 16'h7FFE, 3, 1'b0);

        // Two wait cycles per byte.
        ack_wait = 2;
        push(16'h8000, 16'h1234, 16'h7FFF, 8'h12, 16'h7FFE, 8'h34, 16'h7FFE, 7, 1'b0);
        ack_wait = 0;

        // Second call_enable while busy must be dropped.
        push(16'h9000, 16'hCAFE, 16'h8FFF, 8'hCA, 16'h8FFE, 8'hFE, 16'h8FFE, 3, 1'b1);

        // Reset while the low byte is waiting for its acknowledge.
        exp_wr.push_back({16'h7FFF, 8'h12});
        @(posedge clk);
        #1;
        ifc.call_enable = 1'b1;
        ifc.sp_in       = 16'h8000;
        ifc.ret_addr    = 16'h1234;
        @(posedge clk);
        #1;
        ifc.call_enable = 1'b0;
        @(negedge clk);
        ack_block = 1'b1;
        @(negedge clk);
        check("rst_pre_we", 32'(ifc.mem_we), 32'd1);
        check("rst_pre_addr", 32'(ifc.mem_addr), 32'h7FFE);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rst       = 1'b0;
        ack_block = 1'b0;
        repeat (5) @(negedge clk);

        // Fresh push after the abandoned one.
        push(16'h8000, 16'h1234, 16'h7FFF, 8'h12, 16'h7FFE, 8'h34, 16'h7FFE, 3, 1'b0);

`ifdef SP_PUSH_OVF_CHECK_EN
        // Just below the legal floor: rejected, sticky flag.
        @(posedge clk);
        #1;
        ifc.call_enable = 1'b1;
        ifc.sp_in       = 16'h0101;
        ifc.ret_addr    = 16'hBEEF;
        @(posedge clk);
        #1;
        ifc.call_enable = 1'b0;
        @(negedge clk);
        check("ovf_c1", 32'(ifc.overflow), 32'd1);
        check("ovf_no_we", 32'(ifc.mem_we), 32'd0);
        check("ovf_busy_c1", 32'(ifc.busy), 32'd1);
        @(negedge clk);
        check("ovf_busy_c2", 32'(ifc.busy), 32'd0);
        repeat (4) @(negedge clk);
        check("ovf_sticky", 32'(ifc.overflow), 32'd1);

        // Exactly at the floor: normal push.
        push(16'h0102, 16'hC3A5, 16'h0101, 8'hC3, 16'h0100, 8'hA5, 16'h0100, 3, 1'b0);
        check("ovf_sticky2", 32'(ifc.overflow), 32'd1);

        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ovf_cleared", 32'(ifc.overflow), 32'd0);
`else
        // Address wrap below zero.
        push(16'h0001, 16'hABCD, 16'h0000, 8'hAB, 16'hFFFF, 8'hCD, 16'hFFFF, 3, 1'b0);
        check("wrap_no_ovf", 32'(ifc.overflow), 32'd0);
`endif

        repeat (5) @(negedge clk);
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        check("sp_queue_empty", 32'(exp_sp.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sp_push_unit.md
# sp_push_unit

- Call-side counterpart of the return-path stack-pointer increment.
- On a CALL, pushes a 16-bit return address onto the byte-wide stack memory as two byte writes with a request/acknowledge handshake.
- Then hands the decremented stack pointer (SP − 2) back to the SP register.
- Sits between the control unit (call strobe, return address), the SP register and the data-memory write port.

## Interface
- `STACK_LIMIT`, default 16'h0100: lowest legal stack address; used only with the overflow check.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `call_enable` in 1: request to push; sampled only in IDLE.
- `ret_addr` in 16: return address to push; captured with `call_enable`.
- `sp_in` in 16: current SP; captured with `call_enable`.
- `sp_out` out 16: updated SP (captured SP − 2); registered.
- `sp_we` out 1: one-cycle strobe; SP register loads `sp_out`.
- `busy` out 1: high from the cycle after capture until the return to IDLE.
- `mem_addr` out 16: byte address of the current write.
- `mem_wdata` out 8: byte being written.
- `mem_we` out 1: write request; held until acknowledged.
- `mem_ack` in 1: memory accepted the byte this cycle.
- `overflow` out 1: sticky stack-overflow flag.

## Operation
- **States:** IDLE, WR_HI, WR_LO, DONE, plus ERR when the overflow check is compiled in.
- **IDLE:**
  - `call_enable`=1 latches `ret_addr` → RA and `sp_in` → SP0.
  - Next state is WR_HI, or ERR (see Configuration).
- **WR_HI:**
  - `mem_addr`=SP0−1, `mem_wdata`=RA[15:8], `mem_we`=1.
  - `mem_ack`=1 → WR_LO; otherwise stay, outputs stable.
- **WR_LO:**
  - `mem_addr`=SP0−2, `mem_wdata`=RA[7:0], `mem_we`=1.
  - `mem_ack`=1 → DONE.
- **DONE:**
  - `sp_out`=SP0−2, `sp_we`=1 for exactly this cycle.
  - → IDLE.
- **Layout:** little-endian; the low byte sits at the new SP, matching the return path, which reads at SP and then adds 2.
- **Arithmetic:** all address arithmetic is 16-bit unsigned, modulo 2^16.
  - Example: SP0=16'h0001 writes 16'h0000 then 16'hFFFF; `sp_out`=16'hFFFF.
- **`call_enable` while busy:** ignored, not queued.
- **`mem_ack` outside a write state:** ignored.
- **`sp_out`** holds its last value outside DONE.

## Timing
- **Reset values:**
  - State IDLE.
  - `sp_out`=0, `sp_we`=0, `busy`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `overflow`=0.
- **Cycle numbering:** cycle 0 is the edge where `call_enable` is sampled. Cycle 1 is WR_HI, with `mem_we` and `busy` high.
- **Latency with zero-wait memory** (`mem_ack` high whenever `mem_we` is high):
  - Cycle 1: WR_HI.
  - Cycle 2: WR_LO.
  - Cycle 3: DONE, `sp_we`=1.
  - Cycle 4: IDLE, `busy`=0.
  - A new `call_enable` is accepted in cycle 4.
- **Wait states:** each cycle with `mem_ack`=0 adds one cycle.
- **Handshake rules:**
  - A byte completes in the cycle where `mem_we` and `mem_ack` are both high.
  - `mem_addr`/`mem_wdata` are stable while `mem_we` is high and unacknowledged.
  - `mem_we` drops, or advances to the next byte, on the following edge.
- **`rst` mid-operation:**
  - Returns to IDLE at that edge; all outputs take their reset values.
  - A partially written byte pair is abandoned and the SP is not updated.

## Configuration
- **`SP_PUSH_OVF_CHECK_EN` defined:**
  - Overflow is detected at capture when SP0 < `STACK_LIMIT`+2 (unsigned), and the FSM goes to ERR.
  - ERR makes no memory writes and raises no `sp_we`.
  - `overflow` is set in cycle 1 and stays set until `rst`.
  - `busy` is high for the ERR cycle only; ERR → IDLE.
- **`SP_PUSH_OVF_CHECK_EN` undefined:**
  - No check; `overflow` is tied 0.
  - `STACK_LIMIT` is unused; pushes wrap modulo 2^16.

## Test plan
- **Basic push:** `sp_in`=16'h8000, `ret_addr`=16'h1234, `mem_ack` tied 1.
  - Writes 8'h12 @16'h7FFF in cycle 1 and 8'h34 @16'h7FFE in cycle 2.
  - `sp_we`=1 with `sp_out`=16'h7FFE in cycle 3; `busy` low in cycle 4.
- **Wait states:** same stimulus, `mem_ack` low for 2 cycles in each write state.
  - Address and data are held stable while waiting.
  - `sp_we` arrives in cycle 7.
- **Busy ignore:** `call_enable` pulsed in cycles 0 and 2 with a different `ret_addr`.
  - Exactly one push of the first value; one `sp_we`.
- **Reset mid-push:** `rst` asserted in WR_LO with ack withheld.
  - Next cycle all outputs are at reset values; no `sp_we` is ever seen.
  - A fresh push afterwards behaves as in the basic push.
- **Wrap (macro undefined):** `sp_in`=16'h0001, `ret_addr`=16'hABCD.
  - Writes 8'hAB @16'h0000 and 8'hCD @16'hFFFF.
  - `sp_out`=16'hFFFF; `overflow`=0.
- **Overflow (macro defined):** `STACK_LIMIT`=16'h0100, `sp_in`=16'h0101.
  - No `mem_we`, no `sp_we`; `overflow`=1 from cycle 1, held until `rst`.
  - With `sp_in`=16'h0102 the push proceeds normally.
